// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and dump FSM state type for the integer
// register file and its dump controller.
//   REG_XLEN - default register data width
//   REG_NUM  - number of architectural registers
//   REG_AW   - register index width
//   dump_state_t - dump scan FSM states (IDLE/SCAN/DONE)
package regfile_pkg;

    localparam int unsigned REG_XLEN = 64;
    localparam int unsigned REG_NUM  = 32;
    localparam int unsigned REG_AW   = 5;

    typedef enum logic [1:0] {
        DUMP_IDLE = 2'd0,
        DUMP_SCAN = 2'd1,
        DUMP_DONE = 2'd2
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_ctrl.sv
// regfile_dump_ctrl: sequencer for the full-register dump scan.
//   clk      - core clock
//   rst      - asynchronous active-low reset
//   i_req    - scan request, sampled only in IDLE
//   o_state  - current FSM state
//   o_idx    - register index presented this cycle (0 outside SCAN)
//   o_valid  - a dump beat is presented this cycle
//   o_done   - one-cycle pulse after the last beat
//   o_busy   - scan in progress (SCAN or DONE)
module regfile_dump_ctrl
    import regfile_pkg::*;
#(
    parameter int unsigned NREG = REG_NUM,
    parameter int unsigned AW   = REG_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    output dump_state_t   o_state,
    output logic [AW-1:0] o_idx,
    output logic          o_valid,
    output logic          o_done,
    output logic          o_busy
);

    dump_state_t   r_state;
    dump_state_t   w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= DUMP_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_valid     = 1'b0;
        o_done      = 1'b0;
        o_busy      = 1'b0;
        o_idx       = '0;
        case (r_state)
            DUMP_IDLE: begin
                if (i_req) begin
                    w_state_nxt = DUMP_SCAN;
                    w_cnt_nxt   = '0;
                end
            end
            DUMP_SCAN: begin
                o_valid = 1'b1;
                o_busy  = 1'b1;
                o_idx   = r_cnt;
                // Counter is cleared on the last beat so it never exceeds NREG-1.
                if (r_cnt == AW'(NREG - 1)) begin
                    w_state_nxt = DUMP_DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            DUMP_DONE: begin
                o_done      = 1'b1;
                o_busy      = 1'b1;
                w_state_nxt = DUMP_IDLE;
            end
            default: begin
                w_state_nxt = DUMP_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_state = r_state;

endmodule

// File: rtl/regfile.sv
// regfile: integer register file x0..x31 with one write port, two
// combinational read ports with write-through bypass, and a sequential
// dump port that scans every register out one per cycle.
//   clk, rst            - core clock, asynchronous active-low reset
//   w_ena/w_addr/w_data - writeback write port (x0 writes discarded)
//   r1_*/r2_*           - combinational read ports (ena=0 or x0 -> 0)
//   dump_req            - start a full scan (sampled in IDLE only)
//   dump_busy/valid/idx/data/done - scan outputs
module regfile
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN = REG_XLEN,
    parameter int unsigned NREG = REG_NUM,
    parameter int unsigned AW   = REG_AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            w_ena,
    input  logic [AW-1:0]   w_addr,
    input  logic [XLEN-1:0] w_data,
    input  logic            r1_ena,
    input  logic [AW-1:0]   r1_addr,
    output logic [XLEN-1:0] r1_data,
    input  logic            r2_ena,
    input  logic [AW-1:0]   r2_addr,
    output logic [XLEN-1:0] r2_data,
    input  logic            dump_req,
    output logic            dump_busy,
    output logic            dump_valid,
    output logic [AW-1:0]   dump_idx,
    output logic [XLEN-1:0] dump_data,
    output logic            dump_done
);

    logic [XLEN-1:0] r_regs [NREG];
    dump_state_t     w_dump_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_ena && (w_addr != '0)) begin
            r_regs[w_addr] <= w_data;
        end
    end

    // Shared read rule for both read ports and the dump port: a write
    // landing on the same edge is forwarded so readers see it immediately.
    function automatic logic [XLEN-1:0] f_read(input logic ena, input logic [AW-1:0] addr);
        if (!ena || (addr == '0)) begin
            return '0;
        end else if (w_ena && (w_addr == addr)) begin
            return w_data;
        end else begin
            return r_regs[addr];
        end
    endfunction

    regfile_dump_ctrl #(
        .NREG (NREG),
        .AW   (AW)
    ) u_dump_ctrl (
        .clk     (clk),
        .rst     (rst),
        .i_req   (dump_req),
        .o_state (w_dump_state),
        .o_idx   (dump_idx),
        .o_valid (dump_valid),
        .o_done  (dump_done),
        .o_busy  (dump_busy)
    );

    always_comb begin
        r1_data   = f_read(r1_ena, r1_addr);
        r2_data   = f_read(r2_ena, r2_addr);
        dump_data = f_read(w_dump_state == DUMP_SCAN, dump_idx);
    end

endmodule
